// File: rtl/cam_pkg.sv
// cam_pkg: shared camera-path constants and the photo FIFO entry type.
package cam_pkg;
   localparam int SHOT_TAG_W  = 8;
   localparam int PHOTO_DEPTH = 16;
   typedef struct packed {
      logic [15:0]           data;
      logic [SHOT_TAG_W-1:0] tag;
   } photo_entry_t;
endpackage

// File: rtl/photo_fifo_mem.sv
// photo_fifo_mem: DEPTH x photo_entry_t storage, one write port, async read.
module photo_fifo_mem
   import cam_pkg::*;
#(
   parameter int DEPTH = PHOTO_DEPTH
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  photo_entry_t             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output photo_entry_t             rdata
);
   photo_entry_t mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/photo_buffer.sv
// photo_buffer: tags exposure shots and queues them for the storage writer.
module photo_buffer
   import cam_pkg::*;
#(
   parameter int DEPTH = PHOTO_DEPTH,
   parameter int TAG_W = SHOT_TAG_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [15:0]              in_data,
   input  logic                     in_valid,
   input  logic                     out_ready,
   input  logic                     clr_ovf,
   output logic [15:0]              out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic [7:0]               drop_count
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0]  rd_ptr, wr_ptr;
   logic [AW:0]    lvl;
   logic [TAG_W-1:0] tag_cnt;
   logic           pop, push, drop;
   photo_entry_t   wr_entry, rd_entry;
   assign out_valid = lvl != '0;
   assign empty     = lvl == '0;
   assign full      = lvl == (AW+1)'(DEPTH);
   assign level     = lvl;
   assign pop  = out_valid && out_ready;
   // a full FIFO still accepts a shot when the head leaves in the same cycle
   assign push = in_valid && (!full || pop);
   assign drop = in_valid && full && !pop;
   assign wr_entry = '{data: in_data, tag: SHOT_TAG_W'(tag_cnt)};
   assign out_data = empty ? '0 : rd_entry.data;
   assign out_tag  = empty ? '0 : TAG_W'(rd_entry.tag);
   photo_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         lvl        <= '0;
         tag_cnt    <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (in_valid) tag_cnt <= tag_cnt + 1'b1;
         if (push != pop) lvl <= push ? lvl + 1'b1 : lvl - 1'b1;
         // a drop in the clearing cycle still counts as the first new drop
         if (drop) begin
            overflow   <= 1'b1;
            drop_count <= clr_ovf ? 8'd1 : (drop_count == 8'hFF ? drop_count : drop_count + 1'b1);
         end else if (clr_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
         end
      end
   end
endmodule

// File: tb/tb_photo_buffer.sv
// tb_photo_buffer: scenario tasks plus a FIFO scoreboard checked on every pop.
module tb_photo_buffer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr_ovf = 1'b0;
   logic [15:0] out_data;
   logic [7:0]  out_tag;
   logic        out_valid;
   logic [4:0]  level;
   logic        full, empty, overflow;
   logic [7:0]  drop_count;
   typedef struct { logic [15:0] d; logic [7:0] t; } exp_t;
   exp_t sb[$];
   int   tag_m = 0;
   int   lvl_m = 0;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   photo_buffer dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .out_ready(out_ready), .clr_ovf(clr_ovf), .out_data(out_data),
      .out_tag(out_tag), .out_valid(out_valid), .level(level), .full(full),
      .empty(empty), .overflow(overflow), .drop_count(drop_count)
   );
   // every accepted head entry must match the oldest expected shot
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected: got data=%0d tag=%0d, scoreboard empty", out_data, out_tag);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (out_data !== e.d || out_tag !== e.t) begin
               bad++;
               $display("FAIL pop_order: got data=%0d tag=%0d, want data=%0d tag=%0d", out_data, out_tag, e.d, e.t);
            end
         end
      end
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic [15:0] d, input logic r, input logic c);
      bit pop_m, push_m;
      in_valid = v; in_data = d; out_ready = r; clr_ovf = c;
      pop_m  = (lvl_m != 0) && r;
      push_m = v && (lvl_m < 16 || pop_m);
      if (push_m) sb.push_back('{d: d, t: 8'(tag_m)});
      if (v) tag_m = (tag_m + 1) % 256;
      lvl_m = lvl_m + int'(push_m) - int'(pop_m);
      tick();
      in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
   endtask
   task automatic do_reset;
      in_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      sb.delete(); tag_m = 0; lvl_m = 0;
   endtask
   task automatic test_reset;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if ({empty, out_valid, level, out_data, out_tag} !== {1'b1, 1'b0, 5'd0, 16'd0, 8'd0}) begin
            bad++;
            $display("FAIL reset_idle: empty=%b valid=%b level=%0d data=%0d tag=%0d", empty, out_valid, level, out_data, out_tag);
         end
      end
   endtask
   task automatic test_single;
      do_reset();
      drive(1, 16'd84, 0, 0);
      total++;
      if ({out_valid, out_data, out_tag, level} !== {1'b1, 16'd84, 8'd0, 5'd1}) begin
         bad++;
         $display("FAIL single_shot: valid=%b data=%0d tag=%0d level=%0d, want 1/84/0/1", out_valid, out_data, out_tag, level);
      end
      drive(0, 0, 1, 0);
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL single_drain: empty=%b want 1", empty);
      end
   endtask
   task automatic test_burst;
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         drive(1, 16'(i * 256), 1, 0);
         drive(0, 0, 1, 0);
         drive(0, 0, 1, 0);
      end
      total++;
      if ({empty, overflow, sb.size() == 0} !== 3'b101) begin
         bad++;
         $display("FAIL burst_end: empty=%b overflow=%b pending=%0d, want 1/0/0", empty, overflow, sb.size());
      end
   endtask
   task automatic test_overflow;
      do_reset();
      for (int i = 0; i < 18; i++) drive(1, 16'(100 + i), 0, 0);
      total++;
      if ({full, level, overflow, drop_count} !== {1'b1, 5'd16, 1'b1, 8'd2}) begin
         bad++;
         $display("FAIL overflow_state: full=%b level=%0d ovf=%b drops=%0d, want 1/16/1/2", full, level, overflow, drop_count);
      end
      for (int i = 0; i < 16; i++) drive(0, 0, 1, 0);
      total++;
      if (empty !== 1'b1) begin
         bad++;
         $display("FAIL overflow_drain: empty=%b want 1", empty);
      end
      drive(1, 16'd999, 0, 0);
      total++;
      if ({out_data, out_tag} !== {16'd999, 8'd18}) begin
         bad++;
         $display("FAIL post_drop_tag: data=%0d tag=%0d, want 999/18", out_data, out_tag);
      end
      drive(0, 0, 1, 0);
   endtask
   task automatic test_full_pop;
      do_reset();
      for (int i = 0; i < 16; i++) drive(1, 16'(i), 0, 0);
      drive(1, 16'hAAAA, 1, 0);
      total++;
      if ({level, overflow, drop_count} !== {5'd16, 1'b0, 8'd0}) begin
         bad++;
         $display("FAIL full_pop: level=%0d ovf=%b drops=%0d, want 16/0/0", level, overflow, drop_count);
      end
      drive(1, 16'h1111, 0, 0);
      drive(1, 16'h2222, 0, 0);
      drive(1, 16'h3333, 0, 1);
      total++;
      if ({overflow, drop_count} !== {1'b1, 8'd1}) begin
         bad++;
         $display("FAIL clr_with_drop: ovf=%b drops=%0d, want 1/1", overflow, drop_count);
      end
      drive(0, 0, 0, 1);
      total++;
      if ({overflow, drop_count} !== {1'b0, 8'd0}) begin
         bad++;
         $display("FAIL clr_only: ovf=%b drops=%0d, want 0/0", overflow, drop_count);
      end
      for (int i = 0; i < 16; i++) drive(0, 0, 1, 0);
      total++;
      if ({empty, sb.size() == 0} !== 2'b11) begin
         bad++;
         $display("FAIL full_pop_drain: empty=%b pending=%0d, want 1/0", empty, sb.size());
      end
   endtask
   task automatic test_mid_reset;
      do_reset();
      for (int i = 0; i < 5; i++) drive(1, 16'(500 + i), 0, 0);
      total++;
      if (level !== 5'd5) begin
         bad++;
         $display("FAIL pre_reset_level: level=%0d want 5", level);
      end
      reset = 1'b0;
      #1;
      total++;
      if ({empty, full, out_valid, level, out_data, out_tag, overflow, drop_count} !==
          {1'b1, 1'b0, 1'b0, 5'd0, 16'd0, 8'd0, 1'b0, 8'd0}) begin
         bad++;
         $display("FAIL async_reset: empty=%b full=%b valid=%b level=%0d data=%0d tag=%0d", empty, full, out_valid, level, out_data, out_tag);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      sb.delete(); tag_m = 0; lvl_m = 0;
      drive(1, 16'd77, 0, 0);
      total++;
      if ({out_valid, out_data, out_tag, level} !== {1'b1, 16'd77, 8'd0, 5'd1}) begin
         bad++;
         $display("FAIL post_reset_shot: valid=%b data=%0d tag=%0d level=%0d, want 1/77/0/1", out_valid, out_data, out_tag, level);
      end
      drive(0, 0, 1, 0);
   endtask
   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_full_pop();
      test_mid_reset();
      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
